// File: rtl/gol_vga_display_pkg.sv
// Shared constants for the Game of Life VGA renderer: 640x480@60 timing, board size, colours.
// GRID_RGB_DEF exists only when GOL_GRID_LINES_EN is defined.
package gol_vga_display_pkg;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FRONT   = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BACK    = 48;
   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FRONT   = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BACK    = 33;

   localparam int BOARD_N     = 16;
   localparam int BOARD_CELLS = BOARD_N * BOARD_N;
   localparam int CNT_W       = 10;

   localparam logic [11:0] LIVE_RGB_DEF = 12'h0F0;
   localparam logic [11:0] DEAD_RGB_DEF = 12'h222;
`ifdef GOL_GRID_LINES_EN
   localparam logic [11:0] GRID_RGB_DEF = 12'h444;
`endif

   // One registered output pixel: colour and both syncs travel together.
   typedef struct packed {
      logic        hsync;
      logic        vsync;
      logic [11:0] rgb;
   } vga_px_t;

endpackage

// File: rtl/gol_vga_display_vga_timing_gen.sv
// vga_timing_gen: pixel-tick divider, h/v raster counters, raw active-low syncs and visible flag.
module vga_timing_gen
   import gol_vga_display_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int H_VISIBLE = VGA_H_VISIBLE,
   parameter int H_FRONT   = VGA_H_FRONT,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BACK    = VGA_H_BACK,
   parameter int V_VISIBLE = VGA_V_VISIBLE,
   parameter int V_FRONT   = VGA_V_FRONT,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BACK    = VGA_V_BACK
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             tick,
   output logic [CNT_W-1:0] h,
   output logic [CNT_W-1:0] v,
   output logic             hsync,
   output logic             vsync,
   output logic             visible
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [CNT_W-1:0] HS_LO    = CNT_W'(H_VISIBLE + H_FRONT);
   localparam logic [CNT_W-1:0] HS_HI    = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] VS_LO    = CNT_W'(V_VISIBLE + V_FRONT);
   localparam logic [CNT_W-1:0] VS_HI    = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);

   logic [DIV_W-1:0] div;

   assign tick = (div == DIV_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    div <= '0;
      else if (tick) div <= '0;
      else           div <= div + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h <= '0;
         v <= '0;
      end else if (tick) begin
         if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
         end else begin
            h <= h + 1'b1;
         end
      end
   end

   assign hsync   = !((h >= HS_LO) && (h < HS_HI));
   assign vsync   = !((v >= VS_LO) && (v < VS_HI));
   assign visible = (h < H_VIS) && (v < V_VIS);

endmodule

// File: rtl/gol_vga_display.sv
// gol_vga_display: draws a frame-snapshotted 16x16 Game of Life board, centred, on 640x480@60 VGA.
// Define GOL_GRID_LINES_EN to outline each cell's top and left edge in GRID_RGB.
module gol_vga_display
   import gol_vga_display_pkg::*;
#(
   parameter int          CLK_DIV   = 4,
   parameter int          CELL_PX   = 24,
   parameter int          X_OFF     = 128,
   parameter int          Y_OFF     = 48,
   parameter logic [11:0] LIVE_RGB  = LIVE_RGB_DEF,
   parameter logic [11:0] DEAD_RGB  = DEAD_RGB_DEF,
`ifdef GOL_GRID_LINES_EN
   parameter logic [11:0] GRID_RGB  = GRID_RGB_DEF,
`endif
   // Raster geometry defaults to 640x480@60.
   parameter int          H_VISIBLE = VGA_H_VISIBLE,
   parameter int          H_FRONT   = VGA_H_FRONT,
   parameter int          H_SYNC    = VGA_H_SYNC,
   parameter int          H_BACK    = VGA_H_BACK,
   parameter int          V_VISIBLE = VGA_V_VISIBLE,
   parameter int          V_FRONT   = VGA_V_FRONT,
   parameter int          V_SYNC    = VGA_V_SYNC,
   parameter int          V_BACK    = VGA_V_BACK
) (
   input  logic                   ClkPort,
   input  logic                   reset_n,
   input  logic [BOARD_CELLS-1:0] board_i,
   input  logic [15:0]            gen_cnt_i,
   output logic                   hsync_o,
   output logic                   vsync_o,
   output logic [3:0]             vga_r_o,
   output logic [3:0]             vga_g_o,
   output logic [3:0]             vga_b_o,
   output logic                   frame_o,
   output logic [15:0]            gen_snap_o
);

   localparam int PX_W     = $clog2(CELL_PX + 1);
   localparam int BOARD_PX = BOARD_N * CELL_PX;
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [CNT_W-1:0] SNAP_V = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] X_LO   = CNT_W'(X_OFF);
   localparam logic [CNT_W-1:0] X_HI   = CNT_W'(X_OFF + BOARD_PX);
   localparam logic [CNT_W-1:0] Y_LO   = CNT_W'(Y_OFF);
   localparam logic [CNT_W-1:0] Y_HI   = CNT_W'(Y_OFF + BOARD_PX);
   // Sub-counters are cleared on the tick that moves h/v onto the board's first column/line.
   localparam logic [CNT_W-1:0] X_PRE  = (X_OFF == 0) ? H_LAST : CNT_W'(X_OFF - 1);
   localparam logic [CNT_W-1:0] Y_PRE  = (Y_OFF == 0) ? V_LAST : CNT_W'(Y_OFF - 1);
   localparam logic [PX_W-1:0]  PX_LAST   = PX_W'(CELL_PX - 1);
   localparam logic [4:0]       BOARD_END = 5'(BOARD_N);

   logic                   tick, visible, hsync_raw, vsync_raw;
   logic [CNT_W-1:0]       h, v;
   logic [PX_W-1:0]        px_x, px_y;
   logic [4:0]             col, row;
   logic [BOARD_CELLS-1:0] board_snap;
   logic                   line_end, in_board, snap_now;
   logic [7:0]             cell_idx;
   logic [11:0]            rgb;
   vga_px_t                pix;

   vga_timing_gen #(
      .CLK_DIV(CLK_DIV),
      .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
      .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
   ) u_timing (
      .clk(ClkPort), .rst_n(reset_n), .tick(tick), .h(h), .v(v),
      .hsync(hsync_raw), .vsync(vsync_raw), .visible(visible)
   );

   assign line_end = (h == H_LAST);
   assign snap_now = tick && (h == '0) && (v == SNAP_V);

   always_ff @(posedge ClkPort or negedge reset_n) begin
      if (!reset_n) begin
         px_x <= '0;
         col  <= '0;
      end else if (tick) begin
         if (h == X_PRE) begin
            px_x <= '0;
            col  <= '0;
         end else if (col != BOARD_END) begin
            if (px_x == PX_LAST) begin
               px_x <= '0;
               col  <= col + 1'b1;
            end else begin
               px_x <= px_x + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge ClkPort or negedge reset_n) begin
      if (!reset_n) begin
         px_y <= '0;
         row  <= '0;
      end else if (tick && line_end) begin
         if (v == Y_PRE) begin
            px_y <= '0;
            row  <= '0;
         end else if (row != BOARD_END) begin
            if (px_y == PX_LAST) begin
               px_y <= '0;
               row  <= row + 1'b1;
            end else begin
               px_y <= px_y + 1'b1;
            end
         end
      end
   end

   // Snapshot lands on a non-visible pixel, so a frame never mixes two generations.
   always_ff @(posedge ClkPort or negedge reset_n) begin
      if (!reset_n) begin
         board_snap <= '0;
         gen_snap_o <= '0;
         frame_o    <= 1'b0;
      end else begin
         frame_o <= snap_now;
         if (snap_now) begin
            board_snap <= board_i;
            gen_snap_o <= gen_cnt_i;
         end
      end
   end

   assign in_board = (h >= X_LO) && (h < X_HI) && (v >= Y_LO) && (v < Y_HI);
   assign cell_idx = {row[3:0], col[3:0]};

   always_comb begin
      rgb = 12'h000;
      if (visible && in_board) begin
         rgb = board_snap[cell_idx] ? LIVE_RGB : DEAD_RGB;
`ifdef GOL_GRID_LINES_EN
         if ((px_x == '0) || (px_y == '0)) rgb = GRID_RGB;
`endif
      end
   end

   always_ff @(posedge ClkPort or negedge reset_n) begin
      if (!reset_n)  pix <= '{hsync: 1'b1, vsync: 1'b1, rgb: 12'h000};
      else if (tick) pix <= '{hsync: hsync_raw, vsync: vsync_raw, rgb: rgb};
   end

   assign hsync_o = pix.hsync;
   assign vsync_o = pix.vsync;
   assign {vga_r_o, vga_g_o, vga_b_o} = pix.rgb;

endmodule

// File: tb/tb_gol_vga_display.sv
// Bench for gol_vga_display on a shrunken raster (80x56 pixel frame, 2-px cells) so whole
// frames, snapshots and a mid-line reset fit in a short run; every clock is checked against a model.
`timescale 1ns/1ps
module tb_gol_vga_display;

   localparam int D    = 2;
   localparam int HV   = 64, HF = 4, HS = 8, HB = 4;
   localparam int VV   = 48, VF = 2, VS = 2, VB = 4;
   localparam int HT   = HV + HF + HS + HB;
   localparam int VT   = VV + VF + VS + VB;
   localparam int CELL = 2, XO = 16, YO = 8;
   localparam int FRAME_CYC = HT * VT * D;
   localparam logic [11:0] LIVE = 12'h0F0;
   localparam logic [11:0] DEAD = 12'h222;
`ifdef GOL_GRID_LINES_EN
   localparam logic [11:0] GRID = 12'h444;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   logic [255:0] board_i;
   logic [15:0]  gen_cnt_i;
   logic         hsync_o, vsync_o, frame_o;
   logic [3:0]   vga_r_o, vga_g_o, vga_b_o;
   logic [15:0]  gen_snap_o;

   gol_vga_display #(
      .CLK_DIV(D), .CELL_PX(CELL), .X_OFF(XO), .Y_OFF(YO),
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .ClkPort(clk), .reset_n(reset_n), .board_i(board_i), .gen_cnt_i(gen_cnt_i),
      .hsync_o(hsync_o), .vsync_o(vsync_o), .vga_r_o(vga_r_o), .vga_g_o(vga_g_o),
      .vga_b_o(vga_b_o), .frame_o(frame_o), .gen_snap_o(gen_snap_o)
   );

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad = 0;
   int n = 0;            // clock edges since reset release
   int chg_n = 0;
   int pat_idx = 0;
   logic [255:0] pat [8];
   logic [255:0] snap_m = '0;
   logic [15:0]  gen_m = '0;
   logic [30:0]  exp_q[$];  // {hsync, vsync, rgb[11:0], frame, gen[15:0]}

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h n=%0d t=%0t", tag, got, want, n, $time);
      end
   endtask

   // Reference: which pixel is on the pins follows from the edge count alone.
   task automatic model_push();
      logic hs, vs, fr;
      logic [11:0] rgb;
      int p, h, v, r, c;
      hs = 1'b1; vs = 1'b1; fr = 1'b0; rgb = 12'h000;
      if (reset_n && n >= D) begin
         p  = n / D - 1;
         h  = p % HT;
         v  = (p / HT) % VT;
         hs = !(h >= HV + HF && h < HV + HF + HS);
         vs = !(v >= VV + VF && v < VV + VF + VS);
         fr = (n % D == 0) && (h == 0) && (v == VV);
         if (fr) begin
            snap_m = board_i;
            gen_m  = gen_cnt_i;
         end
         if (h < HV && v < VV && h >= XO && h < XO + 16 * CELL && v >= YO && v < YO + 16 * CELL) begin
            r   = (v - YO) / CELL;
            c   = (h - XO) / CELL;
            rgb = snap_m[r * 16 + c] ? LIVE : DEAD;
`ifdef GOL_GRID_LINES_EN
            if ((h - XO) % CELL == 0 || (v - YO) % CELL == 0) rgb = GRID;
`endif
         end
      end
      exp_q.push_back({hs, vs, rgb, fr, gen_m});
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_hsync"}, 16'(hsync_o), 16'h1);
      check_eq({tag, "_vsync"}, 16'(vsync_o), 16'h1);
      check_eq({tag, "_rgb"}, 16'({vga_r_o, vga_g_o, vga_b_o}), 16'h0);
      check_eq({tag, "_frame"}, 16'(frame_o), 16'h0);
      check_eq({tag, "_gen_snap"}, gen_snap_o, 16'h0);
   endtask

   // ---------------- driver ----------------
   task automatic step();
      logic [30:0] w;
      @(posedge clk);
      if (reset_n) n++;
      @(negedge clk);
      model_push();
      w = exp_q.pop_front();
      check_eq("hsync", 16'(hsync_o), 16'(w[30]));
      check_eq("vsync", 16'(vsync_o), 16'(w[29]));
      check_eq("rgb", 16'({vga_r_o, vga_g_o, vga_b_o}), 16'(w[28:17]));
      check_eq("frame", 16'(frame_o), 16'(w[16]));
      check_eq("gen_snap", gen_snap_o, w[15:0]);
      if (reset_n && n == chg_n) begin
         board_i = pat[pat_idx % 8];
         pat_idx++;
         chg_n   = chg_n + FRAME_CYC;
      end
      if ($urandom_range(0, 3) == 0) gen_cnt_i = 16'($urandom);
   endtask

   initial begin
      board_i   = {8{$urandom()}};
      gen_cnt_i = 16'($urandom);
      pat[0] = 256'h1;
      pat[1] = {1'b1, 255'b0};
      pat[2] = '1;
      for (int i = 3; i < 8; i++) pat[i] = {8{$urandom()}};

      #3 reset_n = 1'b0;
      #1 check_reset("por");
      repeat (3) step();
      reset_n = 1'b1;
      chg_n = $urandom_range(10 * HT * D, 30 * HT * D);

      // Frames 0..3 full, then reset in the middle of a board line of frame 4.
      while (n < 4 * FRAME_CYC + (20 * HT + XO + 5) * D + 1) step();
      #1 reset_n = 1'b0;
      n = 0;
      snap_m = '0;
      gen_m = '0;
      #1 check_reset("mid_line");
      repeat (4) step();
      reset_n = 1'b1;
      chg_n = $urandom_range(10 * HT * D, 30 * HT * D);

      while (n < FRAME_CYC + VV * HT * D + 200) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
